// File: rtl/memory_stage_if.sv
// ============================================================================
// memory_stage_if
// M-stage inputs from execute and W-stage outputs toward writeback/hazard unit.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface memory_stage_if #(
  parameter int WORD_SIZE = 32
);
  logic [WORD_SIZE-1:0] ALUResultM;
  logic [WORD_SIZE-1:0] WriteDataM;
  logic [WORD_SIZE-1:0] PCPlus4M;
  logic [4:0]           RdM;
  logic                 RegWriteM;
  logic                 MemWriteM;
  logic [1:0]           ResultSrcM;
  logic                 StallM;
  logic                 RegWriteW;
  logic [4:0]           RdW;
  logic [WORD_SIZE-1:0] ResultW;

  modport master (
    output ALUResultM, WriteDataM, PCPlus4M, RdM, RegWriteM, MemWriteM, ResultSrcM,
    input  StallM, RegWriteW, RdW, ResultW
  );

  modport slave (
    input  ALUResultM, WriteDataM, PCPlus4M, RdM, RegWriteM, MemWriteM, ResultSrcM,
    output StallM, RegWriteW, RdW, ResultW
  );
endinterface

`default_nettype wire

// File: rtl/memory_stage.sv
// ============================================================================
// memory_stage
// Pipeline M stage: word data memory, load-latency stall FSM, MEM/WB register.
// Revision: 1.0
// ============================================================================
`default_nettype none

module memory_stage #(
  parameter int WORD_SIZE   = 32,
  parameter int DMEM_DEPTH  = 256,
  parameter int MEM_LATENCY = 2
) (
  input  logic          clk,
  input  logic          rst,
  memory_stage_if.slave bus
);
  localparam int ADDR_W = $clog2(DMEM_DEPTH);
  localparam int CNT_W  = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(MEM_LATENCY - 1);
  localparam bit               MULTI = (MEM_LATENCY > 1);

  typedef enum logic [0:0] {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [WORD_SIZE-1:0] mem [DMEM_DEPTH];

  logic [ADDR_W-1:0]    index;
  logic                 load;
  logic                 stall;

  logic                 reg_write_w;
  logic [4:0]           rd_w;
  logic [1:0]           result_src_w;
  logic [WORD_SIZE-1:0] alu_result_w;
  logic [WORD_SIZE-1:0] pc_plus4_w;
  logic [WORD_SIZE-1:0] read_data_w;
  logic [WORD_SIZE-1:0] result_w;

  assign index = bus.ALUResultM[ADDR_W+1:2];
  assign load  = (bus.ResultSrcM == 2'b01) && !bus.MemWriteM;
  // The final latency cycle (cnt==LAST in WAIT) releases the stall so the result is captured.
  assign stall = load && !rst && MULTI && (state == IDLE || cnt != LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load && MULTI) begin
            state <= WAIT;
            cnt   <= CNT_W'(1);
          end
        end
        WAIT: begin
          if (cnt == LAST) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && bus.MemWriteM) begin
      mem[index] <= bus.WriteDataM;
    end
  end

  // A stalled load inserts a bubble so W never sees the same instruction twice.
  always_ff @(posedge clk) begin
    if (rst || stall) begin
      reg_write_w  <= 1'b0;
      rd_w         <= '0;
      result_src_w <= 2'b00;
      alu_result_w <= '0;
      pc_plus4_w   <= '0;
      read_data_w  <= '0;
    end else begin
      reg_write_w  <= bus.RegWriteM;
      rd_w         <= bus.RdM;
      result_src_w <= bus.ResultSrcM;
      alu_result_w <= bus.ALUResultM;
      pc_plus4_w   <= bus.PCPlus4M;
      read_data_w  <= mem[index];
    end
  end

  always_comb begin
    result_w = '0;
    case (result_src_w)
      2'b00:   result_w = alu_result_w;
      2'b01:   result_w = read_data_w;
      2'b10:   result_w = pc_plus4_w;
      default: result_w = '0;
    endcase
  end

  assign bus.StallM    = stall;
  assign bus.RegWriteW = reg_write_w;
  assign bus.RdW       = rd_w;
  assign bus.ResultW   = result_w;

endmodule

`default_nettype wire

// File: tb/tb_memory_stage.sv
// ============================================================================
// tb_memory_stage
// Scoreboard bench for memory_stage at load latencies 2, 1 and 4.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_memory_stage;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Index 0: latency 2, index 1: latency 1, index 2: latency 4.
  int lat [3] = '{2, 1, 4};

  logic [31:0] alu_d [3];
  logic [31:0] wd_d  [3];
  logic [31:0] pc_d  [3];
  logic [4:0]  rd_d  [3];
  logic        rw_d  [3];
  logic        mw_d  [3];
  logic [1:0]  src_d [3];

  logic        stall_o [3];
  logic        rww_o   [3];
  logic [4:0]  rdw_o   [3];
  logic [31:0] res_o   [3];

  logic [31:0] mem_m [3][256];

  typedef struct {
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] res;
  } exp_t;
  exp_t sb [$];

  memory_stage_if #(.WORD_SIZE(32)) b0 ();
  memory_stage_if #(.WORD_SIZE(32)) b1 ();
  memory_stage_if #(.WORD_SIZE(32)) b2 ();

  memory_stage #(.WORD_SIZE(32), .DMEM_DEPTH(256), .MEM_LATENCY(2)) u_lat2 (.clk(clk), .rst(rst), .bus(b0));
  memory_stage #(.WORD_SIZE(32), .DMEM_DEPTH(256), .MEM_LATENCY(1)) u_lat1 (.clk(clk), .rst(rst), .bus(b1));
  memory_stage #(.WORD_SIZE(32), .DMEM_DEPTH(256), .MEM_LATENCY(4)) u_lat4 (.clk(clk), .rst(rst), .bus(b2));

  assign b0.ALUResultM = alu_d[0]; assign b0.WriteDataM = wd_d[0]; assign b0.PCPlus4M = pc_d[0];
  assign b0.RdM = rd_d[0]; assign b0.RegWriteM = rw_d[0]; assign b0.MemWriteM = mw_d[0]; assign b0.ResultSrcM = src_d[0];
  assign b1.ALUResultM = alu_d[1]; assign b1.WriteDataM = wd_d[1]; assign b1.PCPlus4M = pc_d[1];
  assign b1.RdM = rd_d[1]; assign b1.RegWriteM = rw_d[1]; assign b1.MemWriteM = mw_d[1]; assign b1.ResultSrcM = src_d[1];
  assign b2.ALUResultM = alu_d[2]; assign b2.WriteDataM = wd_d[2]; assign b2.PCPlus4M = pc_d[2];
  assign b2.RdM = rd_d[2]; assign b2.RegWriteM = rw_d[2]; assign b2.MemWriteM = mw_d[2]; assign b2.ResultSrcM = src_d[2];

  assign stall_o[0] = b0.StallM; assign rww_o[0] = b0.RegWriteW; assign rdw_o[0] = b0.RdW; assign res_o[0] = b0.ResultW;
  assign stall_o[1] = b1.StallM; assign rww_o[1] = b1.RegWriteW; assign rdw_o[1] = b1.RdW; assign res_o[1] = b1.ResultW;
  assign stall_o[2] = b2.StallM; assign rww_o[2] = b2.RegWriteW; assign rdw_o[2] = b2.RdW; assign res_o[2] = b2.ResultW;

  task automatic drive(input int d, input logic [31:0] alu, wd, pc, input logic [4:0] rd,
                       input logic rw, mw, input logic [1:0] src);
    alu_d[d] = alu; wd_d[d] = wd; pc_d[d] = pc; rd_d[d] = rd;
    rw_d[d]  = rw;  mw_d[d] = mw; src_d[d] = src;
  endtask

  task automatic idle(input int d);
    @(negedge clk);
    drive(d, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 2'b00);
  endtask

  // Issue one instruction, follow it through any stall, then check its W result.
  task automatic issue(input int d, input logic [31:0] alu, wd, pc, input logic [4:0] rd,
                       input logic rw, mw, input logic [1:0] src, input string tag);
    exp_t e;
    exp_t got;
    int   idx;
    int   n;
    bit   is_load;
    idx     = int'(alu[9:2]);
    is_load = (src == 2'b01) && !mw;
    e.rw = rw;
    e.rd = rd;
    case (src)
      2'b00:   e.res = alu;
      2'b01:   e.res = mem_m[d][idx];
      2'b10:   e.res = pc;
      default: e.res = 32'd0;
    endcase
    sb.push_back(e);
    if (mw) mem_m[d][idx] = wd;

    @(negedge clk);
    drive(d, alu, wd, pc, rd, rw, mw, src);
    n = 0;
    #1;
    while (stall_o[d] === 1'b1 && n < 16) begin
      n++;
      @(posedge clk); #1;
      checks++;
      if (rww_o[d] !== 1'b0 || rdw_o[d] !== 5'd0 || res_o[d] !== 32'd0) begin
        errors++;
        $display("FAIL %s bubble lat%0d: got rw=%b rd=%0d res=%h, need rw=0 rd=0 res=0",
                 tag, lat[d], rww_o[d], rdw_o[d], res_o[d]);
      end
    end
    checks++;
    if (n != (is_load ? lat[d] - 1 : 0)) begin
      errors++;
      $display("FAIL %s stall_cycles lat%0d: got %0d, need %0d", tag, lat[d], n, is_load ? lat[d] - 1 : 0);
    end
    @(posedge clk); #1;
    got = sb.pop_front();
    checks++;
    if (res_o[d] !== got.res || rdw_o[d] !== got.rd || rww_o[d] !== got.rw) begin
      errors++;
      $display("FAIL %s result lat%0d: got res=%h rd=%0d rw=%b, need res=%h rd=%0d rw=%b",
               tag, lat[d], res_o[d], rdw_o[d], rww_o[d], got.res, got.rd, got.rw);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int d = 0; d < 3; d++) drive(d, 32'd8, 32'd0, 32'd0, 5'd7, 1'b1, 1'b0, 2'b01);
    #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (stall_o[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset_stall lat%0d: got %b, need 0", lat[d], stall_o[d]);
      end
    end
    @(posedge clk); @(posedge clk); #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (rww_o[d] !== 1'b0 || rdw_o[d] !== 5'd0 || res_o[d] !== 32'd0) begin
        errors++;
        $display("FAIL reset_w lat%0d: got rw=%b rd=%0d res=%h, need 0/0/0", lat[d], rww_o[d], rdw_o[d], res_o[d]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 3; d++) drive(d, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 2'b00);
  endtask

  task automatic test_alu();
    issue(0, 32'd30, 32'd0, 32'd0, 5'd5, 1'b1, 1'b0, 2'b00, "alu_pass");
    issue(0, 32'd77, 32'd0, 32'd0, 5'd6, 1'b1, 1'b0, 2'b11, "src_reserved");
    issue(0, 32'd9,  32'd0, 32'd0, 5'd0, 1'b1, 1'b0, 2'b00, "rd_x0");
    idle(0);
  endtask

  task automatic test_store_load(input int d);
    issue(d, 32'd8, 32'hDEADBEEF, 32'd0, 5'd0, 1'b0, 1'b1, 2'b00, "store8");
    issue(d, 32'd8, 32'd0,        32'd0, 5'd7, 1'b1, 1'b0, 2'b01, "load8");
    idle(d);
  endtask

  task automatic test_jal();
    issue(0, 32'd123, 32'd0, 32'd34, 5'd1, 1'b1, 1'b0, 2'b10, "jal_link");
    idle(0);
  endtask

  task automatic test_reset_mid_load();
    @(negedge clk);
    drive(0, 32'd8, 32'd0, 32'd0, 5'd7, 1'b1, 1'b0, 2'b01);
    #1;
    checks++;
    if (stall_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL midload_stall_start: got %b, need 1", stall_o[0]);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (stall_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL midload_stall_in_rst: got %b, need 0", stall_o[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    drive(0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 2'b00);
    #1;
    checks++;
    if (stall_o[0] !== 1'b0 || rww_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL midload_after_rst: got stall=%b rw=%b, need 0/0", stall_o[0], rww_o[0]);
    end
    issue(0, 32'd8, 32'd0, 32'd0, 5'd7, 1'b1, 1'b0, 2'b01, "reload8");
    checks++;
    if (res_o[0] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL mem_retained: got %h, need deadbeef", res_o[0]);
    end
    idle(0);
  endtask

  task automatic test_store_priority();
    issue(0, 32'd8, 32'hCAFEF00D, 32'd0, 5'd9,  1'b1, 1'b1, 2'b01, "store_wins");
    issue(0, 32'd8, 32'd0,        32'd0, 5'd10, 1'b1, 1'b0, 2'b01, "load_after_store");
    idle(0);
  endtask

  task automatic test_wrap();
    issue(0, 32'h400, 32'h12345678, 32'd0, 5'd0, 1'b0, 1'b1, 2'b00, "store_wrap");
    issue(0, 32'h000, 32'd0,        32'd0, 5'd3, 1'b1, 1'b0, 2'b01, "load_wrap");
    issue(0, 32'h00B, 32'd0,        32'd0, 5'd4, 1'b1, 1'b0, 2'b01, "load_misaligned");
    idle(0);
  endtask

  task automatic test_back_to_back();
    issue(2, 32'd4,  32'hA5A5_0004, 32'd0, 5'd0,  1'b0, 1'b1, 2'b00, "b2b_store");
    issue(2, 32'd8,  32'd0,         32'd0, 5'd11, 1'b1, 1'b0, 2'b01, "b2b_load1");
    issue(2, 32'd4,  32'd0,         32'd0, 5'd12, 1'b1, 1'b0, 2'b01, "b2b_load2");
    issue(2, 32'd50, 32'd0,         32'd0, 5'd13, 1'b1, 1'b0, 2'b00, "b2b_alu");
    idle(2);
  endtask

  initial begin
    for (int d = 0; d < 3; d++) drive(d, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 2'b00);
    test_reset();
    test_alu();
    test_store_load(0);
    test_store_load(1);
    test_store_load(2);
    test_jal();
    test_reset_mid_load();
    test_store_priority();
    test_wrap();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
